shift_sequencer: RTL
====================

SHIFT_SEQUENCER -- requirements
Module: shift_sequencer

Interface
REQ-001 Parameter WIDTH, default 16, data width in bits; WIDTH SHALL equal 2**AMTW.
REQ-002 Parameter AMTW, default 4, shift-amount width in bits.
REQ-003 Port clk  input  1  single clock; all state SHALL change on its rising edge.
REQ-004 Port rst_n  input  1  reset, asynchronous and active-low.
REQ-005 Port in_valid  input  1  request strobe; in_data and in_amt are valid.
REQ-006 Port in_ready  output  1  sequencer can accept a request.
REQ-007 Port in_data  input  WIDTH  operand to shift.
REQ-008 Port in_amt  input  AMTW  left-shift amount, 0..WIDTH-1.
REQ-009 Port out_valid  output  1  out_data holds a finished result.
REQ-010 Port out_ready  input  1  consumer takes the result.
REQ-011 Port out_data  output  WIDTH  shifted result.
REQ-012 Port busy  output  1  high whenever the state is not IDLE.

Function
REQ-013 The block SHALL be a three-state FSM: IDLE, SHIFT, DONE.
REQ-014 in_ready SHALL be 1 only in IDLE; a request is accepted on a rising edge where in_valid=1 and in_ready=1.
REQ-015 On accept: acc <= in_data, rem <= in_amt; next state is DONE if in_amt==0, else SHIFT.
REQ-016 In SHIFT, each cycle: step = min(rem,3); acc <= acc shifted left by step with zero fill; rem <= rem-step.
REQ-017 In SHIFT, next state SHALL be DONE when rem-step==0, else SHIFT.
REQ-018 Latency from the accept edge to out_valid high SHALL be 1+ceil(in_amt/3) cycles (amt 0 -> 1, 3 -> 2, 4 -> 3, 15 -> 6).
REQ-019 In DONE, out_valid=1 and out_data=acc, both held stable until out_ready=1.
REQ-020 DONE with out_ready=1 SHALL go to IDLE on that edge; a new request SHALL NOT be accepted in the same cycle (in_ready=0 in DONE).
REQ-021 out_data SHALL equal acc in every state; consumers SHALL sample it only when out_valid=1.
REQ-022 in_valid, in_data and in_amt SHALL be ignored outside IDLE; no input is buffered.
REQ-023 out_ready SHALL be ignored outside DONE.
REQ-024 Bits shifted past bit WIDTH-1 SHALL be discarded (no carry or overflow flag).

Reset
REQ-025 rst_n=0 SHALL immediately force state=IDLE, acc=0, rem=0, out_valid=0, busy=0, and in_ready=1 after release.
REQ-026 Reset asserted in SHIFT or DONE SHALL abort the operation; no result is delivered for it.
REQ-027 The first accept SHALL be possible on the first rising edge after rst_n deasserts.

Configuration
REQ-028 Macro SHIFT_SEQ_ROTATE_EN, when defined, SHALL add port in_rot (input, 1), latched on accept.
REQ-029 With SHIFT_SEQ_ROTATE_EN and in_rot=1, each step SHALL rotate left, so bits leaving bit WIDTH-1 re-enter at bit 0; with in_rot=0, the shift is logical.
REQ-030 Without SHIFT_SEQ_ROTATE_EN, in_rot SHALL NOT exist and every operation SHALL be a logical left shift; latency is identical in both builds.

Verification
REQ-031 Reset, then in_data=16'h1234, in_amt=0 -> out_valid high 1 cycle after accept, out_data=16'h1234.
REQ-032 in_data=16'h0001, in_amt=15 -> busy for 6 cycles, out_data=16'h8000; in_ready=0 throughout.
REQ-033 in_data=16'hFFFF, in_amt=4, out_ready held 0 for 5 cycles -> out_data=16'hFFF0 stays stable; IDLE on the first edge with out_ready=1.
REQ-034 in_valid held 1 with a second request pending during SHIFT -> second request ignored until IDLE, then accepted; first result unaffected.
REQ-035 Assert rst_n=0 mid-SHIFT (in_amt=9, second cycle) -> out_valid=0, acc=0 immediately; no result is produced for that request.
REQ-036 With SHIFT_SEQ_ROTATE_EN: in_data=16'h8001, in_amt=1, in_rot=1 -> 16'h0003; the same request with in_rot=0 -> 16'h0002.

Source files
------------

// File: rtl/shift_sequencer.sv
// Multi-cycle left shifter: accepts one operand, shifts it at most 3 bits per cycle, then holds the result until it is taken.
// Optional rotate mode is enabled with `define SHIFT_SEQ_ROTATE_EN (adds input in_rot).
module shift_sequencer #(
  parameter int WIDTH = 16,
  parameter int AMTW  = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [AMTW-1:0]  in_amt,
`ifdef SHIFT_SEQ_ROTATE_EN
  input  logic             in_rot,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] acc, acc_next, shl;
  logic [AMTW-1:0]  rem, rem_next, step;

  always_comb step = (rem > AMTW'(3)) ? AMTW'(3) : rem;
  assign shl = acc << step;

`ifdef SHIFT_SEQ_ROTATE_EN
  logic               rot, rot_next;
  logic [2*WIDTH-1:0] dbl;
  logic [WIDTH-1:0]   step_val;
  // Shifting the doubled word leaves the rotated value in the upper half.
  assign dbl      = {acc, acc} << step;
  assign step_val = rot ? dbl[2*WIDTH-1:WIDTH] : shl;
`else
  logic [WIDTH-1:0]   step_val;
  assign step_val = shl;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      acc   <= '0;
      rem   <= '0;
`ifdef SHIFT_SEQ_ROTATE_EN
      rot   <= 1'b0;
`endif
    end else begin
      state <= state_next;
      acc   <= acc_next;
      rem   <= rem_next;
`ifdef SHIFT_SEQ_ROTATE_EN
      rot   <= rot_next;
`endif
    end
  end

  always_comb begin
    state_next = state;
    acc_next   = acc;
    rem_next   = rem;
`ifdef SHIFT_SEQ_ROTATE_EN
    rot_next   = rot;
`endif
    case (state)
      IDLE: begin
        if (in_valid) begin
          acc_next   = in_data;
          rem_next   = in_amt;
`ifdef SHIFT_SEQ_ROTATE_EN
          rot_next   = in_rot;
`endif
          state_next = (in_amt == '0) ? DONE : SHIFT;
        end
      end
      SHIFT: begin
        acc_next = step_val;
        rem_next = rem - step;
        if (rem == step) state_next = DONE;
      end
      DONE: begin
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign out_data  = acc;

endmodule
